// File: rtl/cfg_chain_loader_pkg.sv
// Shared types and sizing helpers for the configuration scan-chain loader.
package cfg_chain_loader_pkg;

  // Bitstream word width and the bit-index width needed to walk one word.
  localparam int WORD_W = 32;
  localparam int IDX_W  = 5;

  // Loader state encodings.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Number of bitstream words needed to cover a chain of len flops.
  function automatic int words_for(input int len);
    return (len + WORD_W - 1) / WORD_W;
  endfunction

  // Number of leading bits of the final word that reach the chain.
  function automatic int last_bits(input int len);
    return ((len % WORD_W) != 0) ? (len % WORD_W) : WORD_W;
  endfunction

endpackage

// File: rtl/cfg_chain_loader_serializer.sv
// Word-to-bit serializer: one word buffer shifted MSB first at one bit per cycle,
// refilled in the same cycle its last valid bit leaves so the chain never idles
// while the source keeps up.
module cfg_chain_loader_serializer
  import cfg_chain_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,  // pass active and more words still wanted
  input  logic              i_flush,   // drop whatever the buffer holds
  input  logic              i_last,    // the final bit of the pass shifts this cycle
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_bit,
  output logic              o_en
);

  logic [WORD_W-1:0] r_buf;
  logic              r_full;
  logic [IDX_W-1:0]  r_idx;

  logic w_word_end;
  logic w_accept;

  // The buffer empties after its 32nd bit, or early when the pass is over
  // (the unused low bits of the final word are simply discarded).
  assign w_word_end = r_full & ((r_idx == IDX_W'(WORD_W - 1)) | i_last);
  assign o_ready    = i_enable & (~r_full | w_word_end);
  assign w_accept   = o_ready & i_valid;

  // Chain-facing outputs come straight from the buffer registers.
  assign o_en  = r_full;
  assign o_bit = r_full & r_buf[WORD_W-1];

  // Buffer load, shift and drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf  <= {WORD_W{1'b0}};
      r_full <= 1'b0;
      r_idx  <= {IDX_W{1'b0}};
    end else if (i_flush) begin
      r_buf  <= {WORD_W{1'b0}};
      r_full <= 1'b0;
      r_idx  <= {IDX_W{1'b0}};
    end else if (w_accept) begin
      r_buf  <= i_data;
      r_full <= 1'b1;
      r_idx  <= {IDX_W{1'b0}};
    end else if (w_word_end) begin
      r_buf  <= {WORD_W{1'b0}};
      r_full <= 1'b0;
      r_idx  <= {IDX_W{1'b0}};
    end else if (r_full) begin
      r_buf  <= {r_buf[WORD_W-2:0], 1'b0};
      r_full <= 1'b1;
      r_idx  <= r_idx + IDX_W'(1);
    end else begin
      r_buf  <= r_buf;
      r_full <= r_full;
      r_idx  <= r_idx;
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Host-side driver for the fabric configuration scan chain. Streams a word-based
// bitstream serially into the chain and optionally re-streams it while comparing
// the bits returning from the chain tail.
module cfg_chain_loader
  import cfg_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 1376,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              prog_in,
  output logic              prog_en,
  input  logic              prog_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam int WORDS = words_for(CHAIN_LEN);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_verify;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_word_cnt;
  logic             r_err;
  logic [CNT_W-1:0] r_mm_cnt;

  logic w_active;
  logic w_start_ok;
  logic w_abort;
  logic w_last;
  logic w_enable;
  logic w_accept;
  logic w_mis;

  assign w_active   = (r_state == ST_LOAD) | (r_state == ST_VERIFY);
  assign w_start_ok = (r_state == ST_IDLE) & start;
  assign w_abort    = w_active & abort;
  // Pass ends on the cycle the CHAIN_LEN-th bit shifts into the chain.
  assign w_last     = w_active & prog_en & (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  // Words are only requested while the pass still needs them; an abort
  // withholds ready so no word is silently swallowed.
  assign w_enable   = w_active & ~abort & (r_word_cnt < CNT_W'(WORDS));
  assign w_accept   = s_valid & s_ready;
  assign w_mis      = (r_state == ST_VERIFY) & prog_en & (prog_out != prog_in);

  cfg_chain_loader_serializer u_ser (
    .clk      (prog_clk),
    .rst      (rst),
    .i_enable (w_enable),
    .i_flush  (w_abort),
    .i_last   (w_last),
    .i_data   (s_data),
    .i_valid  (s_valid),
    .o_ready  (s_ready),
    .o_bit    (prog_in),
    .o_en     (prog_en)
  );

  assign busy         = w_active;
  assign done         = (r_state == ST_DONE);
  assign err          = r_err;
  assign mismatch_cnt = r_mm_cnt;

  // State register.
  always_ff @(posedge prog_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort takes priority over a pass finishing.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_LOAD;
        else       w_state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort)       w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = r_verify ? ST_VERIFY : ST_DONE;
        else             w_state_nxt = ST_LOAD;
      end
      ST_VERIFY: begin
        if (abort)       w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_DONE;
        else             w_state_nxt = ST_VERIFY;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture whether this load is followed by a verify pass.
  always_ff @(posedge prog_clk) begin
    if (rst) begin
      r_verify <= 1'b0;
    end else if (w_start_ok) begin
      r_verify <= verify_en;
    end else begin
      r_verify <= r_verify;
    end
  end

  // Per-pass bit and word counters; both restart at zero for every pass.
  always_ff @(posedge prog_clk) begin
    if (rst) begin
      r_bit_cnt  <= {CNT_W{1'b0}};
      r_word_cnt <= {CNT_W{1'b0}};
    end else if (!w_active || w_last || abort) begin
      r_bit_cnt  <= {CNT_W{1'b0}};
      r_word_cnt <= {CNT_W{1'b0}};
    end else begin
      r_bit_cnt  <= prog_en  ? (r_bit_cnt + CNT_W'(1))  : r_bit_cnt;
      r_word_cnt <= w_accept ? (r_word_cnt + CNT_W'(1)) : r_word_cnt;
    end
  end

  // Sticky error and saturating mismatch count, both cleared by an accepted start.
  always_ff @(posedge prog_clk) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_mm_cnt <= {CNT_W{1'b0}};
    end else if (w_start_ok) begin
      r_err    <= 1'b0;
      r_mm_cnt <= {CNT_W{1'b0}};
    end else begin
      r_err    <= r_err | w_abort | w_mis;
      r_mm_cnt <= (w_mis && (r_mm_cnt != {CNT_W{1'b1}})) ? (r_mm_cnt + CNT_W'(1)) : r_mm_cnt;
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: three instances (chain lengths 40, 32, 33), each
// driving its own shift-register model of the scan chain.
module tb_cfg_chain_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic        verify_en = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic [2:0]  start_v = 3'b000;

  logic [2:0]  rdy, pin, pen, pout, busy, done, err;
  logic [15:0] mm [3];

  logic [39:0] ch0 = 40'h0;
  logic [31:0] ch1 = 32'h0;
  logic [32:0] ch2 = 33'h0;

  int cyc = 0;
  int en_cnt [3] = '{0, 0, 0};
  int gap_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] src [8];

  always #5 clk = ~clk;

  assign pout = {ch2[32], ch1[31], ch0[39]};

  cfg_chain_loader #(.CHAIN_LEN(40)) u_dut40 (
    .prog_clk(clk), .rst(rst), .start(start_v[0]), .verify_en(verify_en), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[0]), .prog_in(pin[0]), .prog_en(pen[0]),
    .prog_out(pout[0]), .busy(busy[0]), .done(done[0]), .err(err[0]), .mismatch_cnt(mm[0]));

  cfg_chain_loader #(.CHAIN_LEN(32)) u_dut32 (
    .prog_clk(clk), .rst(rst), .start(start_v[1]), .verify_en(verify_en), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[1]), .prog_in(pin[1]), .prog_en(pen[1]),
    .prog_out(pout[1]), .busy(busy[1]), .done(done[1]), .err(err[1]), .mismatch_cnt(mm[1]));

  cfg_chain_loader #(.CHAIN_LEN(33)) u_dut33 (
    .prog_clk(clk), .rst(rst), .start(start_v[2]), .verify_en(verify_en), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy[2]), .prog_in(pin[2]), .prog_en(pen[2]),
    .prog_out(pout[2]), .busy(busy[2]), .done(done[2]), .err(err[2]), .mismatch_cnt(mm[2]));

  // Scan-chain models: pure shift registers, head at bit 0, tail at the MSB.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pen[0]) ch0 <= {ch0[38:0], pin[0]};
    if (pen[1]) ch1 <= {ch1[30:0], pin[1]};
    if (pen[2]) ch2 <= {ch2[31:0], pin[2]};
  end

  // Activity counters sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      en_cnt[i]   <= en_cnt[i] + int'(pen[i]);
      gap_cnt[i]  <= gap_cnt[i] + int'(busy[i] & ~pen[i]);
      done_cnt[i] <= done_cnt[i] + int'(done[i]);
    end
  end

  typedef struct {
    int              inst;
    bit              ver;
    int              n;
    logic [0:3][31:0] w;
    int              stall_after;
    int              stall_len;
    int              exp_taken;
    int              exp_en;
    int              exp_gap;
    int              exp_done;
    bit              exp_err;
    int              exp_mm;
    logic [63:0]     exp_img;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] img(input int i);
    case (i)
      0:       return {24'h0, ch0};
      1:       return {32'h0, ch1};
      default: return {31'h0, ch2};
    endcase
  endfunction

  task automatic set_src(input logic [0:3][31:0] w);
    for (int i = 0; i < 4; i++) src[i] = w[i];
  endtask

  // Pulse start for one instance; returns at the first LOAD cycle (posedge+1).
  task automatic do_start(input int inst, input bit ver);
    verify_en = ver;
    start_v = 3'b000;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v = 3'b000;
    verify_en = 1'b0;
  endtask

  // Word source: offers src[] in order, optionally withholds for stall_len cycles once
  // stall_after words are taken, and optionally fires abort/rst once kill_at bits have
  // shifted. Returns at the negedge of the first non-busy cycle.
  task automatic stream(input int inst, input int n, input int stall_after, input int stall_len,
                        input int kill_at, input bit kill_rst, input int exp_taken,
                        output int taken, output int ready_late, output int kill_gap,
                        output bit timed_out);
    int  stall_cnt = 0;
    int  c = 0;
    int  kcyc = 0;
    int  base_en = en_cnt[inst];
    bit  killed = 1'b0;
    taken = 0; ready_late = 0; kill_gap = -1; timed_out = 1'b0;
    while (1) begin
      abort = 1'b0;
      rst = 1'b0;
      if (!killed && kill_at >= 0 && (en_cnt[inst] - base_en) == kill_at) begin
        if (kill_rst) rst = 1'b1;
        else          abort = 1'b1;
        killed = 1'b1;
        kcyc = cyc;
      end
      if (taken == stall_after && stall_cnt < stall_len) begin
        s_valid = 1'b0;
        stall_cnt++;
      end else if (taken < n) begin
        s_valid = 1'b1;
        s_data = src[taken];
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      if (busy[inst] && rdy[inst] && taken >= exp_taken) ready_late++;
      if (s_valid && rdy[inst]) taken++;
      if (!busy[inst]) begin
        if (killed) kill_gap = cyc - kcyc;
        break;
      end
      c++;
      if (c > 400) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v = vt[i];
    int b_en = en_cnt[v.inst];
    int b_gap = gap_cnt[v.inst];
    int b_done = done_cnt[v.inst];
    int taken, late, kg;
    bit to;
    set_src(v.w);
    do_start(v.inst, v.ver);
    stream(v.inst, v.n, v.stall_after, v.stall_len, -1, 1'b0, v.exp_taken, taken, late, kg, to);
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("v%0d timeout", i), 64'(to), 64'd0);
    chk($sformatf("v%0d words_taken", i), 64'(taken), 64'(v.exp_taken));
    chk($sformatf("v%0d ready_after_last", i), 64'(late), 64'd0);
    chk($sformatf("v%0d prog_en_cycles", i), 64'(en_cnt[v.inst] - b_en), 64'(v.exp_en));
    chk($sformatf("v%0d idle_busy_cycles", i), 64'(gap_cnt[v.inst] - b_gap), 64'(v.exp_gap));
    chk($sformatf("v%0d done_pulses", i), 64'(done_cnt[v.inst] - b_done), 64'(v.exp_done));
    chk($sformatf("v%0d err", i), 64'(err[v.inst]), 64'(v.exp_err));
    chk($sformatf("v%0d mismatch_cnt", i), 64'(mm[v.inst]), 64'(v.exp_mm));
    chk($sformatf("v%0d chain_image", i), img(v.inst), v.exp_img);
  endtask

  initial begin
    int taken, late, kg, b_en, b_done;
    bit to;

    // inst, ver, n, words, stall_after, stall_len, taken, en, gap, done, err, mm, image
    vt[0] = '{0, 1'b0, 2, {32'hA5A5A5A5, 32'hFF000000, 32'h0, 32'h0}, -1, 0, 2, 40, 1, 1, 1'b0, 0, 64'hA5A5A5A5FF};
    vt[1] = '{0, 1'b1, 4, {32'hA5A5A5A5, 32'hFF000000, 32'hA5A5A5A5, 32'hFF000000}, -1, 0, 4, 80, 2, 1, 1'b0, 0, 64'hA5A5A5A5FF};
    vt[2] = '{0, 1'b1, 4, {32'hA5A5A5A5, 32'hFF000000, 32'hA5A5A5A4, 32'hFF000000}, -1, 0, 4, 80, 2, 1, 1'b1, 1, 64'hA5A5A5A4FF};
    // 38 withheld cycles after word 0: the buffer drains after 32, leaving 7 empty cycles.
    vt[3] = '{0, 1'b0, 2, {32'hA5A5A5A5, 32'hFF000000, 32'h0, 32'h0}, 1, 38, 2, 40, 8, 1, 1'b0, 0, 64'hA5A5A5A5FF};
    vt[4] = '{1, 1'b0, 2, {32'h12345678, 32'hDEADBEEF, 32'h0, 32'h0}, -1, 0, 1, 32, 1, 1, 1'b0, 0, 64'h12345678};
    vt[5] = '{2, 1'b0, 3, {32'h12345678, 32'h80000000, 32'hFFFFFFFF, 32'h0}, -1, 0, 2, 33, 1, 1, 1'b0, 0, 64'h2468ACF1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {40'h0, rdy, pin, pen, busy, done, err}, 64'h0);
    chk("reset_mismatch_cnt", 64'(mm[0]), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Sync reset mid-VERIFY, after a mismatch has set err and the counter.
    set_src(vt[2].w);
    do_start(0, 1'b1);
    stream(0, 4, -1, 0, 75, 1'b1, 4, taken, late, kg, to);
    chk("rst_verify_latency", 64'(kg), 64'd1);
    chk("rst_verify_outputs", {58'h0, rdy[0], pin[0], pen[0], busy[0], done[0], err[0]}, 64'h0);
    chk("rst_verify_mismatch_cnt", 64'(mm[0]), 64'h0);
    @(posedge clk); #1;

    // Abort in LOAD once 17 bits have shifted; the bit on the wire in the abort
    // cycle still clocks into the chain, so 18 shifts in total.
    set_src(vt[0].w);
    b_en = en_cnt[0];
    b_done = done_cnt[0];
    do_start(0, 1'b0);
    stream(0, 2, -1, 0, 17, 1'b0, 2, taken, late, kg, to);
    chk("abort_latency", 64'(kg), 64'd1);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_prog_en", 64'(pen[0]), 64'd0);
    chk("abort_err", 64'(err[0]), 64'd1);
    chk("abort_shift_count", 64'(en_cnt[0] - b_en), 64'd18);
    s_valid = 1'b1;
    s_data = 32'h0BADF00D;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt[0] - b_done), 64'd0);
    chk("idle_word_not_taken", 64'(rdy[0]), 64'd0);
    s_valid = 1'b0;

    // Abort during VERIFY after a mismatch; the next start clears err and the count.
    set_src(vt[2].w);
    do_start(0, 1'b1);
    stream(0, 4, -1, 0, 75, 1'b0, 4, taken, late, kg, to);
    chk("abort_verify_err", 64'(err[0]), 64'd1);
    chk("abort_verify_mismatch_cnt", 64'(mm[0]), 64'd1);
    @(posedge clk); #1;
    set_src(vt[0].w);
    b_done = done_cnt[0];
    do_start(0, 1'b0);
    chk("restart_clears_err", 64'(err[0]), 64'd0);
    chk("restart_clears_mismatch_cnt", 64'(mm[0]), 64'd0);
    stream(0, 2, -1, 0, -1, 1'b0, 2, taken, late, kg, to);
    repeat (3) @(posedge clk);
    #1;
    chk("restart_timeout", 64'(to), 64'd0);
    chk("restart_done", 64'(done_cnt[0] - b_done), 64'd1);
    chk("restart_image", img(0), 64'hA5A5A5A5FF);

    // Sync reset mid-LOAD.
    set_src(vt[0].w);
    do_start(0, 1'b0);
    stream(0, 2, -1, 0, 20, 1'b1, 2, taken, late, kg, to);
    chk("rst_load_latency", 64'(kg), 64'd1);
    chk("rst_load_outputs", {58'h0, rdy[0], pin[0], pen[0], busy[0], done[0], err[0]}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
